// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: key scanner input, command handshake and display/status signals
interface keypad_entry_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_value;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_operand;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_cnt;
  logic        overflow;
  logic        err;
  logic        timeout;
  modport master (
    output key_valid, key_value, cmd_ready,
    input  cmd_valid, cmd_op, cmd_operand, entry_bcd, digit_cnt, overflow, err, timeout
  );
  modport slave (
    input  key_valid, key_value, cmd_ready,
    output cmd_valid, cmd_op, cmd_operand, entry_bcd, digit_cnt, overflow, err, timeout
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced keypad entry of a 4-digit BCD operand plus operator, issued as a command
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input logic clk,
  input logic reset_p,
  keypad_entry_ctrl_if.slave kp
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DMAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ENTRY, CMD} state_t;
  state_t state;
  logic [DW-1:0] press_cnt, rel_cnt, press_nxt, rel_nxt;
  logic [TW-1:0] timer;
  logic [3:0] last_val, ev_code, op;
  logic last_valid, blocked, started, ev, ev_nxt, same, is_digit, is_op;
  always_comb begin
    same      = last_valid && kp.key_value == last_val;
    press_nxt = !kp.key_valid ? '0 : !same ? DW'(1) : press_cnt == DMAX ? DMAX : press_cnt + 1'b1;
    rel_nxt   = kp.key_valid ? '0 : rel_cnt == DMAX ? DMAX : rel_cnt + 1'b1;
    ev_nxt    = started && !blocked && press_nxt == DMAX;
    is_digit  = ev_code <= 4'd9;
    is_op     = ev_code == 4'ha || ev_code == 4'hb || ev_code == 4'hd || ev_code == 4'he;
  end
  // blocked starts clear (release already stable); a key held as reset drops is blocked on the first cycle
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      press_cnt  <= '0;
      rel_cnt    <= '0;
      last_val   <= '0;
      last_valid <= 1'b0;
      blocked    <= 1'b0;
      started    <= 1'b0;
      ev         <= 1'b0;
      ev_code    <= '0;
    end else begin
      press_cnt  <= press_nxt;
      rel_cnt    <= rel_nxt;
      last_val   <= kp.key_value;
      last_valid <= kp.key_valid;
      started    <= 1'b1;
      ev         <= ev_nxt;
      ev_code    <= kp.key_value;
      blocked    <= (ev_nxt || (!started && kp.key_valid)) ? 1'b1 : rel_nxt == DMAX ? 1'b0 : blocked;
    end
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      state          <= IDLE;
      op             <= '0;
      timer          <= '0;
      kp.cmd_valid   <= 1'b0;
      kp.cmd_op      <= '0;
      kp.cmd_operand <= '0;
      kp.entry_bcd   <= '0;
      kp.digit_cnt   <= '0;
      kp.overflow    <= 1'b0;
      kp.err         <= 1'b0;
      kp.timeout     <= 1'b0;
    end else begin
      kp.overflow <= 1'b0;
      kp.err      <= 1'b0;
      kp.timeout  <= 1'b0;
      case (state)
        IDLE: if (ev) begin
          if (is_digit) begin
            kp.entry_bcd <= {12'h000, ev_code};
            kp.digit_cnt <= 3'd1;
            timer        <= '0;
            state        <= ENTRY;
          end else if (is_op) op <= ev_code;
          else if (ev_code == 4'hf) kp.err <= 1'b1;
          else if (ev_code == 4'hc) op <= '0;
        end
        ENTRY: if (ev) begin
          timer <= '0;
          if (is_digit) begin
            if (kp.digit_cnt == 3'd4) kp.overflow <= 1'b1;
            else begin
              kp.entry_bcd <= {kp.entry_bcd[11:0], ev_code};
              kp.digit_cnt <= kp.digit_cnt + 3'd1;
            end
          end else if (is_op) op <= ev_code;
          else if (ev_code == 4'hf) begin
            kp.cmd_valid   <= 1'b1;
            kp.cmd_op      <= op;
            kp.cmd_operand <= kp.entry_bcd;
            state          <= CMD;
          end else if (ev_code == 4'hc) begin
            kp.entry_bcd <= '0;
            kp.digit_cnt <= '0;
            op           <= '0;
            state        <= IDLE;
          end
        end else if (timer == TLAST) begin
          kp.entry_bcd <= '0;
          kp.digit_cnt <= '0;
          op           <= '0;
          timer        <= '0;
          kp.timeout   <= 1'b1;
          state        <= IDLE;
        end else timer <= timer + 1'b1;
        CMD: if (kp.cmd_ready) begin
          kp.cmd_valid <= 1'b0;
          kp.entry_bcd <= '0;
          kp.digit_cnt <= '0;
          op           <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
